// File: rtl/_bus32_xfer_pkg.sv
// Shared types and constants for the 32-bit bus transfer sequencer.
package _bus32_pkg;

    // Width of the shared data bus and of every destination register.
    localparam int BUS_W = 32;

    // Width of the settle counter; SETTLE must fit in it (0..15).
    localparam int CNT_W = 4;

    // Sequencer states; encodings are fixed so state dumps stay comparable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } xfer_state_e;

endpackage

// File: rtl/_bus32_xfer_capture.sv
// Destination register bank: M x 32-bit registers, one-hot load, async clear,
// flattened onto q with register k at q[32k+31:32k].
module _bus32_capture
    import _bus32_pkg::*;
#(
    parameter int M = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [M-1:0]       ld,
    input  logic [BUS_W-1:0]   d,
    output logic [BUS_W*M-1:0] q
);

    logic [BUS_W-1:0] reg_q [M];
    logic [BUS_W-1:0] reg_d [M];

    // Next value per register: load from the bus only where selected.
    always_comb begin
        for (int unsigned k = 0; k < M; k++) begin
            reg_d[k] = ld[k] ? d : reg_q[k];
        end
    end

    // Register bank with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < M; k++) begin
                reg_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < M; k++) begin
                reg_q[k] <= reg_d[k];
            end
        end
    end

    // Flatten the bank onto the output vector.
    always_comb begin
        q = '0;
        for (int unsigned k = 0; k < M; k++) begin
            q[k*BUS_W +: BUS_W] = reg_q[k];
        end
    end

endmodule

// File: rtl/_bus32_xfer.sv
// Bus transfer sequencer: accepts (src, dst) commands, drives the active-low
// output enable of the chosen source for SETTLE+2 cycles, then captures the
// bus into destination register dst.
// Optional feature macro: BUS32_XFER_STATS_EN adds a 16-bit wrapping
// xfer_count output counting completed captures.
module _bus32_xfer
    import _bus32_pkg::*;
#(
    parameter int N      = 8,
    parameter int M      = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [$clog2(N)-1:0] req_src,
    input  logic [$clog2(M)-1:0] req_dst,
    output logic [N-1:0]         g,
    input  logic [BUS_W-1:0]     y,
    output logic [BUS_W*M-1:0]   q,
    output logic                 done,
    output logic                 err,
    output logic                 busy
`ifdef BUS32_XFER_STATS_EN
    ,
    output logic [15:0]          xfer_count
`endif
);

    localparam int SW = $clog2(N);
    localparam int DW = $clog2(M);

    xfer_state_e      state_q, state_d;
    logic [SW-1:0]    src_q, src_d;
    logic [DW-1:0]    dst_q, dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     g_q, g_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cap_en;
    logic             src_ok;
    logic [M-1:0]     ld;

    // Source index range check; req_src may encode values beyond N-1.
    always_comb begin
        src_ok = (int'(req_src) < N);
    end

    // Next-state, command latch, settle counter and pulse outputs.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cap_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (src_ok) begin
                        src_d   = req_src;
                        dst_d   = req_dst;
                        cnt_d   = CNT_W'(SETTLE);
                        state_d = DRIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LATCH: begin
                cap_en  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gate decode from the next state so g is a clean register: it goes low
    // on the accept edge and releases on the capture edge.
    always_comb begin
        g_d = '1;
        if (state_d != IDLE) begin
            g_d = ~(N'(1) << src_d);
        end
    end

    // One-hot load enable for the destination bank on the capture edge.
    always_comb begin
        ld = '0;
        if (cap_en) begin
            ld = M'(1) << dst_q;
        end
    end

    // Sequencer registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            g_q     <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    _bus32_capture #(
        .M(M)
    ) u_capture (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .d   (y),
        .q   (q)
    );

`ifdef BUS32_XFER_STATS_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    // Capture counter; wraps naturally at 16 bits.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (cap_en) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    // Capture counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

    assign g         = g_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign req_ready = (state_q == IDLE);

endmodule

// File: tb/tb__bus32_xfer.sv
// Bench for _bus32_xfer: an 8-source/SETTLE=1 instance and a 6-source/SETTLE=0
// instance, checked against a transaction-level model of the register bank.
module tb__bus32_xfer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: N=8, M=4, SETTLE=1
    logic         v8, ready8, done8, err8, busy8;
    logic [2:0]   src8;
    logic [1:0]   dst8;
    logic [7:0]   g8;
    logic [31:0]  y8;
    logic [127:0] q8;

    // Instance B: N=6, M=4, SETTLE=0
    logic         v6, ready6, done6, err6, busy6;
    logic [2:0]   src6;
    logic [1:0]   dst6;
    logic [5:0]   g6;
    logic [31:0]  y6;
    logic [127:0] q6;

    // Reference register banks
    logic [31:0] m8 [4];
    logic [31:0] m6 [4];

`ifdef BUS32_XFER_STATS_EN
    logic [15:0] cnt8, cnt6;
    logic [15:0] mcnt8, mcnt6;
`endif

    _bus32_xfer #(.N(8), .M(4), .SETTLE(1)) u8 (
        .clk(clk), .rst(rst), .req_valid(v8), .req_ready(ready8),
        .req_src(src8), .req_dst(dst8), .g(g8), .y(y8), .q(q8),
        .done(done8), .err(err8), .busy(busy8)
`ifdef BUS32_XFER_STATS_EN
        , .xfer_count(cnt8)
`endif
    );

    _bus32_xfer #(.N(6), .M(4), .SETTLE(0)) u6 (
        .clk(clk), .rst(rst), .req_valid(v6), .req_ready(ready6),
        .req_src(src6), .req_dst(dst6), .g(g6), .y(y6), .q(q6),
        .done(done6), .err(err6), .busy(busy6)
`ifdef BUS32_XFER_STATS_EN
        , .xfer_count(cnt6)
`endif
    );

    function automatic logic [127:0] pack8();
        logic [127:0] p;
        for (int k = 0; k < 4; k++) p[32*k +: 32] = m8[k];
        return p;
    endfunction

    function automatic logic [127:0] pack6();
        logic [127:0] p;
        for (int k = 0; k < 4; k++) p[32*k +: 32] = m6[k];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int k = 0; k < 4; k++) begin
            m8[k] = '0;
            m6[k] = '0;
        end
`ifdef BUS32_XFER_STATS_EN
        mcnt8 = '0;
        mcnt6 = '0;
`endif
    endtask

    // At most one enable low on either bus, checked every cycle.
    always @(posedge clk) begin
        #2;
        n_tests++;
        if ($countones(~g8) > 1 || $countones(~g6) > 1) begin
            n_fail++;
            $display("FAIL onehot g8=%b g6=%b required at most one low bit", g8, g6);
        end
    end

    // One full transfer on instance A. The bus shows ye, switching to yl on
    // the last drive cycle; yl is what must be captured. With chain set,
    // req_valid stays high so the next call accepts on the done cycle.
    task automatic xfer8(input logic [2:0] s, input logic [1:0] d,
                         input logic [31:0] ye, input logic [31:0] yl,
                         input bit chain);
        logic [7:0] expg;
        expg = ~(8'h01 << s);
        v8 = 1'b1; src8 = s; dst8 = d; y8 = ye;
        n_tests++;
        if (ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ready8_pre ready=%b required 1", ready8);
        end
        tick();
        // SETTLE+2 = 3 drive cycles
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (g8 !== expg || busy8 !== 1'b1 || done8 !== 1'b0 || ready8 !== 1'b0) begin
                n_fail++;
                $display("FAIL drive8 cyc=%0d g=%h busy=%b done=%b ready=%b required g=%h busy=1 done=0 ready=0",
                         k, g8, busy8, done8, ready8, expg);
            end
            src8 = 3'($urandom);
            dst8 = 2'($urandom);
            if (k == 2) y8 = yl;
            tick();
        end
        m8[d] = yl;
`ifdef BUS32_XFER_STATS_EN
        mcnt8 = mcnt8 + 16'd1;
        n_tests++;
        if (cnt8 !== mcnt8) begin
            n_fail++;
            $display("FAIL count8 xfer_count=%0d required %0d", cnt8, mcnt8);
        end
`endif
        n_tests++;
        if (done8 !== 1'b1 || g8 !== 8'hFF || ready8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL capture8 done=%b g=%h ready=%b busy=%b required done=1 g=ff ready=1 busy=0",
                     done8, g8, ready8, busy8);
        end
        n_tests++;
        if (q8 !== pack8()) begin
            n_fail++;
            $display("FAIL q8 q=%h required %h", q8, pack8());
        end
        y8 = $urandom;
        if (!chain) begin
            v8 = 1'b0;
            tick();
            n_tests++;
            if (done8 !== 1'b0 || g8 !== 8'hFF || busy8 !== 1'b0 || err8 !== 1'b0) begin
                n_fail++;
                $display("FAIL tail8 done=%b g=%h busy=%b err=%b required done=0 g=ff busy=0 err=0",
                         done8, g8, busy8, err8);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v8 = 1'b0; src8 = '0; dst8 = '0; y8 = '0;
        v6 = 1'b0; src6 = '0; dst6 = '0; y6 = '0;
        clear_models();
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (g8 !== 8'hFF || q8 !== '0 || ready8 !== 1'b1 || busy8 !== 1'b0 ||
            done8 !== 1'b0 || err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8 g=%h q=%h ready=%b busy=%b done=%b err=%b required g=ff q=0 ready=1 busy=0 done=0 err=0",
                     g8, q8, ready8, busy8, done8, err8);
        end
        n_tests++;
        if (g6 !== 6'h3F || q6 !== '0 || ready6 !== 1'b1 || busy6 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset6 g=%h q=%h ready=%b busy=%b required g=3f q=0 ready=1 busy=0",
                     g6, q6, ready6, busy6);
        end
`ifdef BUS32_XFER_STATS_EN
        n_tests++;
        if (cnt8 !== 16'd0 || cnt6 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count cnt8=%0d cnt6=%0d required 0", cnt8, cnt6);
        end
`endif
    endtask

    task automatic test_basic();
        xfer8(3'd3, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_y_change();
        xfer8(3'd5, 2'd1, 32'h1, 32'h2, 1'b0);
    endtask

    task automatic test_back_to_back();
        xfer8(3'd0, 3'd0, $urandom, $urandom, 1'b1);
        xfer8(3'd7, 2'd3, $urandom, $urandom, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] yv;
        for (int i = 0; i < 16; i++) begin
            yv = $urandom;
            xfer8(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? $urandom : yv, yv,
                  (i < 15) ? bit'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    task automatic test_reject();
        logic [2:0]  s;
        logic [1:0]  d;
        logic [31:0] yv;
        logic [5:0]  expg;
        // two rejects back to back: src=6 (first out of range), then src=7
        for (int r = 6; r < 8; r++) begin
            v6 = 1'b1; src6 = 3'(r); dst6 = 2'($urandom); y6 = $urandom;
            tick();
            n_tests++;
            if (err6 !== 1'b1 || g6 !== 6'h3F || busy6 !== 1'b0 || ready6 !== 1'b1 || done6 !== 1'b0) begin
                n_fail++;
                $display("FAIL reject6 src=%0d err=%b g=%h busy=%b ready=%b done=%b required err=1 g=3f busy=0 ready=1 done=0",
                         r, err6, g6, busy6, ready6, done6);
            end
        end
        s = 3'($urandom_range(0, 5));
        d = 2'($urandom_range(0, 3));
        yv = $urandom;
        expg = ~(6'h01 << s);
        src6 = s; dst6 = d; y6 = yv;
        tick();
        // SETTLE=0: two drive cycles; out-of-range junk while busy is ignored
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (err6 !== 1'b0 || g6 !== expg || busy6 !== 1'b1 || done6 !== 1'b0) begin
                n_fail++;
                $display("FAIL drive6 cyc=%0d err=%b g=%h busy=%b done=%b required err=0 g=%h busy=1 done=0",
                         k, err6, g6, busy6, done6, expg);
            end
            src6 = 3'd7;
            dst6 = 2'($urandom);
            tick();
        end
        m6[d] = yv;
        n_tests++;
        if (done6 !== 1'b1 || g6 !== 6'h3F || err6 !== 1'b0 || q6 !== pack6()) begin
            n_fail++;
            $display("FAIL capture6 done=%b g=%h err=%b q=%h required done=1 g=3f err=0 q=%h",
                     done6, g6, err6, q6, pack6());
        end
`ifdef BUS32_XFER_STATS_EN
        mcnt6 = mcnt6 + 16'd1;
        n_tests++;
        if (cnt6 !== mcnt6) begin
            n_fail++;
            $display("FAIL count6 xfer_count=%0d required %0d", cnt6, mcnt6);
        end
`endif
        v6 = 1'b0;
        tick();
        n_tests++;
        if (done6 !== 1'b0 || err6 !== 1'b0 || busy6 !== 1'b0) begin
            n_fail++;
            $display("FAIL tail6 done=%b err=%b busy=%b required 0 0 0", done6, err6, busy6);
        end
    endtask

    task automatic test_reset_mid();
        v8 = 1'b1; src8 = 3'd4; dst8 = 2'd1; y8 = $urandom;
        tick();
        v8 = 1'b0;
        tick();
        n_tests++;
        if (g8 !== 8'hEF || busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_drive g=%h busy=%b required g=ef busy=1", g8, busy8);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (g8 !== 8'hFF || q8 !== '0 || q6 !== '0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst g=%h q8=%h q6=%h busy=%b required g=ff q=0 busy=0",
                     g8, q8, q6, busy8);
        end
        clear_models();
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (done8 !== 1'b0 || g8 !== 8'hFF || ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst done=%b g=%h ready=%b required done=0 g=ff ready=1",
                     done8, g8, ready8);
        end
`ifdef BUS32_XFER_STATS_EN
        n_tests++;
        if (cnt8 !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_count xfer_count=%0d required 0", cnt8);
        end
`endif
        xfer8(3'd2, 2'd3, $urandom, 32'hA5A5_0F0F, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_y_change();
        test_back_to_back();
        test_random();
        test_reject();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
